// File: rtl/data_memory_arbiter.sv
// data_memory_arbiter: shares single-port DataMemory between CPU port C and debug/DMA port D; define DMEM_ARB_FIXED_PRIORITY_EN for fixed C-first priority (default round-robin)
module data_memory_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_WORDS  = 32
) (
  input  logic                  Clock,
  input  logic                  Reset_n,
  input  logic                  CReq,
  input  logic                  CWrite,
  input  logic [ADDR_WIDTH-1:0] CAddr,
  input  logic [DATA_WIDTH-1:0] CWData,
  output logic                  CAck,
  output logic [DATA_WIDTH-1:0] CRData,
  output logic                  CErr,
  input  logic                  DReq,
  input  logic                  DWrite,
  input  logic [ADDR_WIDTH-1:0] DAddr,
  input  logic [DATA_WIDTH-1:0] DWData,
  output logic                  DAck,
  output logic [DATA_WIDTH-1:0] DRData,
  output logic                  DErr,
  output logic [ADDR_WIDTH-1:0] MemAddress,
  output logic [DATA_WIDTH-1:0] MemDataIn,
  output logic                  MemEnableWrite,
  input  logic [DATA_WIDTH-1:0] MemDataOut,
  output logic                  Busy
);
  localparam logic [ADDR_WIDTH-1:0] LIMIT = ADDR_WIDTH'(MEM_WORDS * 4);
  typedef enum logic [1:0] {IDLE, ACCESS, RESPOND} state_t;
  state_t                state_q, state_d;
  logic                  win_q, win_d, wr_q, wr_d, err_q, err_d, pick;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, sel_addr;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, crdata_q, crdata_d, drdata_q, drdata_d;
`ifdef DMEM_ARB_FIXED_PRIORITY_EN
  assign pick = !CReq;
`else
  logic last_q, last_d;
  assign pick = (CReq && DReq) ? !last_q : !CReq;
  // pointer remembers the last winner (1 = D); every grant updates it
  always_comb last_d = (state_q == IDLE && (CReq || DReq)) ? pick : last_q;
  // pointer register; reset value 1 makes C win the first contest
  always_ff @(posedge Clock) last_q <= !Reset_n ? 1'b1 : last_d;
`endif
  assign sel_addr = pick ? DAddr : CAddr;
  // next-state, request latching at grant, and read capture on the ACCESS closing edge
  always_comb begin
    state_d  = state_q;
    win_d    = win_q;
    wr_d     = wr_q;
    err_d    = err_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    crdata_d = crdata_q;
    drdata_d = drdata_q;
    case (state_q)
      IDLE: if (CReq || DReq) begin
        state_d = ACCESS;
        win_d   = pick;
        wr_d    = pick ? DWrite : CWrite;
        addr_d  = sel_addr;
        wdata_d = pick ? DWData : CWData;
        err_d   = (sel_addr[1:0] != 2'b00) || (sel_addr >= LIMIT);
      end
      ACCESS: begin
        state_d  = RESPOND;
        crdata_d = (!wr_q && !err_q && !win_q) ? MemDataOut : crdata_q;
        drdata_d = (!wr_q && !err_q &&  win_q) ? MemDataOut : drdata_q;
      end
      default: state_d = IDLE;
    endcase
  end
  // state and latched-request registers with synchronous active-low reset
  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      state_q  <= IDLE;
      win_q    <= 1'b0;
      wr_q     <= 1'b0;
      err_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      crdata_q <= '0;
      drdata_q <= '0;
    end else begin
      state_q  <= state_d;
      win_q    <= win_d;
      wr_q     <= wr_d;
      err_q    <= err_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      crdata_q <= crdata_d;
      drdata_q <= drdata_d;
    end
  end
  assign CAck           = (state_q == RESPOND) && !win_q;
  assign DAck           = (state_q == RESPOND) && win_q;
  assign CErr           = CAck && err_q;
  assign DErr           = DAck && err_q;
  assign CRData         = crdata_q;
  assign DRData         = drdata_q;
  assign MemAddress     = addr_q;
  assign MemDataIn      = wdata_q;
  assign MemEnableWrite = (state_q == ACCESS) && wr_q && !err_q && Reset_n;
  assign Busy           = state_q != IDLE;
endmodule
